// File: rtl/bit_bus_pkg.sv
// rtl/bit_bus_pkg.sv - opcodes, FSM state encoding and read-latency range for the bit bus master
// Shared by bit_bus_master and bit_bus_rmw_alu.
package bit_bus_pkg;

   localparam logic [2:0] OP_READ  = 3'd0;
   localparam logic [2:0] OP_WRITE = 3'd1;
   localparam logic [2:0] OP_SET   = 3'd2;
   localparam logic [2:0] OP_CLR   = 3'd3;
   localparam logic [2:0] OP_TGL   = 3'd4;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_ISSUE = 3'd1,
      ST_RD_WAIT  = 3'd2,
      ST_WR_ISSUE = 3'd3,
      ST_RSP      = 3'd4
   } state_t;

   // Value of the wait counter in the last RD_WAIT cycle (counter starts at 0 on entry).
   function automatic logic [1:0] wait_last(input int lat);
      return (lat > 1) ? 2'(lat - 2) : 2'd0;
   endfunction

endpackage

// File: rtl/bit_bus_rmw_alu.sv
// rtl/bit_bus_rmw_alu.sv - new bit value for SET/CLR/TGL from the bit just read
// Purely combinational; only instantiated when BIT_BUS_RMW_EN is defined.
module bit_bus_rmw_alu
   import bit_bus_pkg::*;
(
   input  logic [2:0] op,
   input  logic       rd,
   output logic       wr
);

   always_comb begin
      wr = rd;
      case (op)
         OP_SET:  wr = 1'b1;
         OP_CLR:  wr = 1'b0;
         OP_TGL:  wr = ~rd;
         default: wr = rd;
      endcase
   end

endmodule

// File: rtl/bit_bus_master.sv
// rtl/bit_bus_master.sv - bit-peripheral bus initiator: one core request -> timed bus strobes -> one response
// Define BIT_BUS_RMW_EN to execute SET/CLR/TGL as read-modify-write; otherwise they are rejected.
module bit_bus_master
   import bit_bus_pkg::*;
#(
   parameter int          RD_LATENCY   = 1,
   parameter logic [15:0] BIT_ADDR_MAX = 16'h00FF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic [2:0]  REQ_OP,
   input  logic [15:0] REQ_ADDR,
   input  logic        REQ_DATA,
   output logic        RSP_VALID,
   output logic        RSP_DATA,
   output logic        RSP_ERR,
   output logic        BIT_EN,
   output logic        BIT_WE,
   output logic        BIT_READ,
   output logic        BIT_WRITE,
   output logic [15:0] BIT_InADDR,
   input  logic        BIT_InDATA,
   output logic [15:0] BIT_OutADDR,
   output logic        BIT_OutDATA
);

   localparam int LAT = (RD_LATENCY < RD_LAT_MIN) ? RD_LAT_MIN :
                        ((RD_LATENCY > RD_LAT_MAX) ? RD_LAT_MAX : RD_LATENCY);
   localparam logic [1:0] WAIT_LAST = wait_last(LAT);

   state_t      state;
   logic        ready_q;
   logic        rsp_valid_q;
   logic        rsp_data_q;
   logic        rsp_err_q;
   logic        en_q;
   logic        we_q;
   logic        read_q;
   logic        write_q;
   logic [15:0] in_addr_q;
   logic [15:0] out_addr_q;
   logic        out_data_q;
   logic [1:0]  wait_cnt;
   logic        req_ok;
   logic        read_done;

`ifdef BIT_BUS_RMW_EN
   logic [2:0]  op_q;
   logic        rmw_bit;

   // Fed straight from BIT_InDATA so the write can issue the cycle after sampling.
   bit_bus_rmw_alu u_rmw_alu (
      .op (op_q),
      .rd (BIT_InDATA),
      .wr (rmw_bit)
   );

   assign req_ok = (REQ_OP <= OP_TGL) && (REQ_ADDR <= BIT_ADDR_MAX);
`else
   assign req_ok = (REQ_OP <= OP_WRITE) && (REQ_ADDR <= BIT_ADDR_MAX);
`endif

   // With latency 1 the data is sampled at the end of the issue cycle itself.
   assign read_done = (LAT == 1) ? (state == ST_RD_ISSUE)
                                 : ((state == ST_RD_WAIT) && (wait_cnt == WAIT_LAST));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= ST_IDLE;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
         en_q        <= 1'b0;
         we_q        <= 1'b0;
         read_q      <= 1'b0;
         write_q     <= 1'b0;
         in_addr_q   <= 16'h0000;
         out_addr_q  <= 16'h0000;
         out_data_q  <= 1'b0;
         wait_cnt    <= 2'd0;
`ifdef BIT_BUS_RMW_EN
         op_q        <= OP_READ;
`endif
      end else begin
         en_q        <= 1'b0;
         we_q        <= 1'b0;
         read_q      <= 1'b0;
         write_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (REQ_VALID && ready_q) begin
                  ready_q <= 1'b0;
`ifdef BIT_BUS_RMW_EN
                  op_q    <= REQ_OP;
`endif
                  if (!req_ok) begin
                     state       <= ST_RSP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_data_q  <= 1'b0;
                  end else if (REQ_OP == OP_WRITE) begin
                     state      <= ST_WR_ISSUE;
                     en_q       <= 1'b1;
                     we_q       <= 1'b1;
                     write_q    <= 1'b1;
                     out_addr_q <= REQ_ADDR;
                     out_data_q <= REQ_DATA;
                  end else begin
                     state     <= ST_RD_ISSUE;
                     en_q      <= 1'b1;
                     read_q    <= 1'b1;
                     in_addr_q <= REQ_ADDR;
                  end
               end else begin
                  ready_q <= 1'b1;
               end
            end
            ST_RD_ISSUE, ST_RD_WAIT: begin
               if (read_done) begin
`ifdef BIT_BUS_RMW_EN
                  if (op_q != OP_READ) begin
                     state      <= ST_WR_ISSUE;
                     en_q       <= 1'b1;
                     we_q       <= 1'b1;
                     write_q    <= 1'b1;
                     out_addr_q <= in_addr_q;
                     out_data_q <= rmw_bit;
                  end else
`endif
                  begin
                     state       <= ST_RSP;
                     rsp_valid_q <= 1'b1;
                     rsp_data_q  <= BIT_InDATA;
                  end
               end else begin
                  state    <= ST_RD_WAIT;
                  wait_cnt <= (state == ST_RD_ISSUE) ? 2'd0 :
                              ((wait_cnt == 2'd3) ? wait_cnt : wait_cnt + 2'd1);
               end
            end
            ST_WR_ISSUE: begin
               state       <= ST_RSP;
               rsp_valid_q <= 1'b1;
               rsp_data_q  <= out_data_q;
            end
            ST_RSP: begin
               state   <= ST_IDLE;
               ready_q <= 1'b1;
            end
            default: begin
               state   <= ST_IDLE;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign REQ_READY   = ready_q;
   assign RSP_VALID   = rsp_valid_q;
   assign RSP_DATA    = rsp_data_q;
   assign RSP_ERR     = rsp_err_q;
   assign BIT_EN      = en_q;
   assign BIT_WE      = we_q;
   assign BIT_READ    = read_q;
   assign BIT_WRITE   = write_q;
   assign BIT_InADDR  = in_addr_q;
   assign BIT_OutADDR = out_addr_q;
   assign BIT_OutDATA = out_data_q;

endmodule

// File: tb/tb_bit_bus_master.sv
// tb/tb_bit_bus_master.sv - self-checking bench for bit_bus_master (RD_LATENCY=2)
// Expectations follow BIT_BUS_RMW_EN when it is defined for the build.
module tb_bit_bus_master;

   localparam logic [2:0] T_READ  = 3'd0;
   localparam logic [2:0] T_WRITE = 3'd1;
   localparam logic [2:0] T_SET   = 3'd2;
   localparam logic [2:0] T_CLR   = 3'd3;
   localparam logic [2:0] T_TGL   = 3'd4;

   typedef struct {
      int   cyc;
      logic data;
      logic err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [15:0] req_addr;
   logic        req_data;
   logic        rsp_valid;
   logic        rsp_data;
   logic        rsp_err;
   logic        bit_en;
   logic        bit_we;
   logic        bit_read;
   logic        bit_write;
   logic [15:0] bit_inaddr;
   logic        bit_indata;
   logic [15:0] bit_outaddr;
   logic        bit_outdata;

   int tests_run = 0;
   int fails = 0;
   exp_t exp_q[$];

   logic mem [0:255];
   logic rd_d1 = 1'b0;
   logic rd_v1 = 1'b0;

   int          obs_rsp_cyc, obs_rsp_cnt, obs_rd_cyc, obs_wr_cyc, obs_en_cnt;
   logic        obs_rsp_data, obs_rsp_err, obs_wr_data, obs_strobe_bad;
   logic [15:0] obs_rd_addr, obs_wr_addr;

   wire [40:0] all_outs = {req_ready, rsp_valid, rsp_data, rsp_err, bit_en, bit_we, bit_read,
                           bit_write, bit_inaddr, bit_outaddr, bit_outdata};

   bit_bus_master #(.RD_LATENCY(2), .BIT_ADDR_MAX(16'h00FF)) dut (
      .CLK(clk), .RST(rst),
      .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_OP(req_op),
      .REQ_ADDR(req_addr), .REQ_DATA(req_data),
      .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data), .RSP_ERR(rsp_err),
      .BIT_EN(bit_en), .BIT_WE(bit_we), .BIT_READ(bit_read), .BIT_WRITE(bit_write),
      .BIT_InADDR(bit_inaddr), .BIT_InDATA(bit_indata),
      .BIT_OutADDR(bit_outaddr), .BIT_OutDATA(bit_outdata)
   );

   always #5 clk = ~clk;

   // Responder: data valid exactly one cycle after the read strobe, inverted garbage otherwise.
   always @(posedge clk) begin
      rd_v1 <= bit_read;
      rd_d1 <= mem[bit_inaddr[7:0]];
      if (bit_write) mem[bit_outaddr[7:0]] <= bit_outdata;
   end
   assign bit_indata = rd_v1 ? rd_d1 : ~rd_d1;

   task automatic run_txn(input logic [2:0] op, input logic [15:0] addr, input logic d);
      int waited;
      obs_rsp_cyc = -1; obs_rsp_cnt = 0; obs_rd_cyc = -1; obs_wr_cyc = -1; obs_en_cnt = 0;
      obs_rsp_data = 1'bx; obs_rsp_err = 1'bx; obs_wr_data = 1'bx; obs_strobe_bad = 1'b0;
      obs_rd_addr = 16'hxxxx; obs_wr_addr = 16'hxxxx;
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_addr = addr; req_data = d;
      waited = 0;
      while (!req_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) begin
         req_valid = 1'b0;
         return;
      end
      @(negedge clk);
      req_valid = 1'b0; req_op = 3'($urandom); req_addr = 16'($urandom); req_data = 1'($urandom);
      for (int k = 1; k <= 8; k++) begin
         if (bit_en) obs_en_cnt++;
         if (bit_read) begin obs_rd_cyc = k; obs_rd_addr = bit_inaddr; end
         if (bit_write) begin obs_wr_cyc = k; obs_wr_addr = bit_outaddr; obs_wr_data = bit_outdata; end
         if ((bit_read && bit_write) || (bit_we != bit_write) || (bit_en != (bit_read || bit_write)))
            obs_strobe_bad = 1'b1;
         if (rsp_valid) begin
            obs_rsp_cnt++;
            if (obs_rsp_cyc < 0) begin
               obs_rsp_cyc = k; obs_rsp_data = rsp_data; obs_rsp_err = rsp_err;
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      #2;
      tests_run++; if (all_outs !== 41'd0) begin fails++; $display("FAIL reset_outs: got %h want 0", all_outs); end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      #1;
      tests_run++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_at_release: got %b want 0", req_ready); end
      @(negedge clk);
      tests_run++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_after: got %b want 1", req_ready); end
      req_valid = 1'b1; req_op = T_WRITE; req_addr = 16'h0030; req_data = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      tests_run++; if (bit_write !== 1'b1) begin fails++; $display("FAIL midreset_strobe_pre: got %b want 1", bit_write); end
      rst = 1'b1;
      #1;
      tests_run++; if (all_outs !== 41'd0) begin fails++; $display("FAIL midreset_outs: got %h want 0", all_outs); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      tests_run++; if (req_ready !== 1'b1) begin fails++; $display("FAIL midreset_ready: got %b want 1", req_ready); end
      tests_run++; if (mem[8'h30] !== 1'b0) begin fails++; $display("FAIL midreset_no_write: got %b want 0", mem[8'h30]); end
   endtask

   task automatic test_write();
      exp_t e;
      exp_q.push_back('{cyc: 2, data: 1'b1, err: 1'b0});
      run_txn(T_WRITE, 16'h0012, 1'b1);
      e = exp_q.pop_front();
      tests_run++; if (obs_rsp_cyc !== e.cyc) begin fails++; $display("FAIL write_rsp_cyc: got %0d want %0d", obs_rsp_cyc, e.cyc); end
      tests_run++; if (obs_rsp_data !== e.data || obs_rsp_err !== e.err) begin fails++; $display("FAIL write_rsp: got d=%b e=%b want d=%b e=%b", obs_rsp_data, obs_rsp_err, e.data, e.err); end
      tests_run++; if (obs_rsp_cnt !== 1) begin fails++; $display("FAIL write_rsp_cnt: got %0d want 1", obs_rsp_cnt); end
      tests_run++; if (obs_wr_cyc !== 1 || obs_en_cnt !== 1 || obs_rd_cyc !== -1) begin fails++; $display("FAIL write_strobes: got wr=%0d en=%0d rd=%0d want 1 1 -1", obs_wr_cyc, obs_en_cnt, obs_rd_cyc); end
      tests_run++; if (obs_wr_addr !== 16'h0012 || obs_wr_data !== 1'b1) begin fails++; $display("FAIL write_bus: got a=%h d=%b want 0012 1", obs_wr_addr, obs_wr_data); end
      tests_run++; if (obs_strobe_bad !== 1'b0) begin fails++; $display("FAIL write_strobe_rules: got %b want 0", obs_strobe_bad); end
      tests_run++; if (mem[8'h12] !== 1'b1) begin fails++; $display("FAIL write_mem: got %b want 1", mem[8'h12]); end
   endtask

   task automatic test_read();
      exp_t e;
      logic [15:0] addrs [2] = '{16'h0005, 16'h0006};
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back('{cyc: 3, data: mem[addrs[i][7:0]], err: 1'b0});
         run_txn(T_READ, addrs[i], 1'($urandom));
         e = exp_q.pop_front();
         tests_run++; if (obs_rsp_cyc !== e.cyc) begin fails++; $display("FAIL read%0d_rsp_cyc: got %0d want %0d", i, obs_rsp_cyc, e.cyc); end
         tests_run++; if (obs_rsp_data !== e.data || obs_rsp_err !== e.err) begin fails++; $display("FAIL read%0d_rsp: got d=%b e=%b want d=%b e=%b", i, obs_rsp_data, obs_rsp_err, e.data, e.err); end
         tests_run++; if (obs_rd_cyc !== 1 || obs_rd_addr !== addrs[i] || obs_wr_cyc !== -1 || obs_en_cnt !== 1) begin fails++; $display("FAIL read%0d_bus: got rd=%0d a=%h wr=%0d en=%0d want 1 %h -1 1", i, obs_rd_cyc, obs_rd_addr, obs_wr_cyc, obs_en_cnt, addrs[i]); end
         tests_run++; if (obs_strobe_bad !== 1'b0) begin fails++; $display("FAIL read%0d_strobe_rules: got %b want 0", i, obs_strobe_bad); end
      end
   endtask

   task automatic test_rmw();
      exp_t e;
      logic [2:0]  ops   [3] = '{T_TGL, T_SET, T_CLR};
      logic [15:0] addrs [3] = '{16'h0007, 16'h0009, 16'h0012};
      logic nv, exp_mem;
      int exp_en;
      for (int i = 0; i < 3; i++) begin
         nv = (ops[i] == T_SET) ? 1'b1 : ((ops[i] == T_CLR) ? 1'b0 : ~mem[addrs[i][7:0]]);
`ifdef BIT_BUS_RMW_EN
         exp_q.push_back('{cyc: 4, data: nv, err: 1'b0});
         exp_en = 2; exp_mem = nv;
`else
         exp_q.push_back('{cyc: 1, data: 1'b0, err: 1'b1});
         exp_en = 0; exp_mem = mem[addrs[i][7:0]];
`endif
         run_txn(ops[i], addrs[i], 1'($urandom));
         e = exp_q.pop_front();
         tests_run++; if (obs_rsp_cyc !== e.cyc) begin fails++; $display("FAIL rmw%0d_rsp_cyc: got %0d want %0d", i, obs_rsp_cyc, e.cyc); end
         tests_run++; if (obs_rsp_data !== e.data || obs_rsp_err !== e.err) begin fails++; $display("FAIL rmw%0d_rsp: got d=%b e=%b want d=%b e=%b", i, obs_rsp_data, obs_rsp_err, e.data, e.err); end
         tests_run++; if (obs_en_cnt !== exp_en) begin fails++; $display("FAIL rmw%0d_en_cnt: got %0d want %0d", i, obs_en_cnt, exp_en); end
         tests_run++; if (mem[addrs[i][7:0]] !== exp_mem) begin fails++; $display("FAIL rmw%0d_mem: got %b want %b", i, mem[addrs[i][7:0]], exp_mem); end
`ifdef BIT_BUS_RMW_EN
         tests_run++; if (obs_rd_cyc !== 1 || obs_wr_cyc !== 3 || obs_wr_addr !== addrs[i] || obs_wr_data !== nv) begin fails++; $display("FAIL rmw%0d_bus: got rd=%0d wr=%0d a=%h d=%b want 1 3 %h %b", i, obs_rd_cyc, obs_wr_cyc, obs_wr_addr, obs_wr_data, addrs[i], nv); end
         tests_run++; if (obs_strobe_bad !== 1'b0) begin fails++; $display("FAIL rmw%0d_strobe_rules: got %b want 0", i, obs_strobe_bad); end
`endif
      end
   endtask

   task automatic test_errors();
      exp_t e;
      logic [2:0]  ops   [5] = '{T_READ, 3'd6, 3'd7, T_WRITE, T_WRITE};
      logic [15:0] addrs [5] = '{16'h0100, 16'h0010, 16'h0010, 16'hFFFF, 16'h00FF};
      int exp_en;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) begin
            exp_q.push_back('{cyc: 2, data: 1'b1, err: 1'b0});
            exp_en = 1;
         end else begin
            exp_q.push_back('{cyc: 1, data: 1'b0, err: 1'b1});
            exp_en = 0;
         end
         run_txn(ops[i], addrs[i], 1'b1);
         e = exp_q.pop_front();
         tests_run++; if (obs_rsp_cyc !== e.cyc) begin fails++; $display("FAIL err%0d_rsp_cyc: got %0d want %0d", i, obs_rsp_cyc, e.cyc); end
         tests_run++; if (obs_rsp_data !== e.data || obs_rsp_err !== e.err) begin fails++; $display("FAIL err%0d_rsp: got d=%b e=%b want d=%b e=%b", i, obs_rsp_data, obs_rsp_err, e.data, e.err); end
         tests_run++; if (obs_en_cnt !== exp_en || obs_rsp_cnt !== 1) begin fails++; $display("FAIL err%0d_activity: got en=%0d rsp=%0d want %0d 1", i, obs_en_cnt, obs_rsp_cnt, exp_en); end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int acc[$];
      int rsp_seen = 0;
      int waited = 0;
      @(negedge clk);
      while (!req_ready && waited < 20) begin @(negedge clk); waited++; end
      req_valid = 1'b1; req_op = T_WRITE;
      for (int k = 0; k < 12; k++) begin
         if (rsp_valid) begin
            rsp_seen++;
            if (exp_q.size() == 0) begin
               tests_run++; fails++; $display("FAIL b2b_extra_rsp: got rsp at %0d want none", k);
            end else begin
               e = exp_q.pop_front();
               tests_run++; if (k !== e.cyc || rsp_data !== e.data || rsp_err !== e.err) begin fails++; $display("FAIL b2b_rsp: got cyc=%0d d=%b e=%b want %0d %b %b", k, rsp_data, rsp_err, e.cyc, e.data, e.err); end
            end
         end
         if (req_valid) begin
            req_addr = 16'h0040 + 16'(acc.size());
            req_data = 1'(acc.size() + 1);
            if (req_ready) begin
               acc.push_back(k);
               exp_q.push_back('{cyc: k + 2, data: req_data, err: 1'b0});
            end
         end
         @(negedge clk);
         if (acc.size() == 3) req_valid = 1'b0;
      end
      tests_run++; if (acc.size() !== 3 || acc[1] - acc[0] !== 3 || acc[2] - acc[1] !== 3) begin fails++; $display("FAIL b2b_spacing: got n=%0d want 3 accepts 3 cycles apart", acc.size()); end
      tests_run++; if (rsp_seen !== 3 || exp_q.size() !== 0) begin fails++; $display("FAIL b2b_rsp_cnt: got %0d pending %0d want 3 0", rsp_seen, exp_q.size()); end
      tests_run++; if (mem[8'h40] !== 1'b1 || mem[8'h41] !== 1'b0 || mem[8'h42] !== 1'b1) begin fails++; $display("FAIL b2b_mem: got %b%b%b want 101", mem[8'h40], mem[8'h41], mem[8'h42]); end
   endtask

   task automatic test_abort();
      exp_t e;
      int rsp_seen = 0;
      int waited = 0;
      @(negedge clk);
      while (!req_ready && waited < 20) begin @(negedge clk); waited++; end
      req_valid = 1'b1; req_op = T_READ; req_addr = 16'h0005;
      @(negedge clk);
      req_valid = 1'b0;
      tests_run++; if (bit_read !== 1'b1) begin fails++; $display("FAIL abort_read_issue: got %b want 1", bit_read); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      tests_run++; if (rsp_valid !== 1'b0 || bit_en !== 1'b0) begin fails++; $display("FAIL abort_outs: got v=%b en=%b want 0 0", rsp_valid, bit_en); end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (rsp_valid) rsp_seen++;
         @(negedge clk);
      end
      tests_run++; if (rsp_seen !== 0) begin fails++; $display("FAIL abort_no_rsp: got %0d want 0", rsp_seen); end
      exp_q.push_back('{cyc: 3, data: mem[8'h05], err: 1'b0});
      run_txn(T_READ, 16'h0005, 1'b0);
      e = exp_q.pop_front();
      tests_run++; if (obs_rsp_cyc !== e.cyc || obs_rsp_data !== e.data || obs_rsp_err !== e.err) begin fails++; $display("FAIL abort_recover: got cyc=%0d d=%b e=%b want %0d %b %b", obs_rsp_cyc, obs_rsp_data, obs_rsp_err, e.cyc, e.data, e.err); end
   endtask

   initial begin
      #100000;
      fails++;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 16'h0000; req_data = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 1'b0;
      mem[8'h05] = 1'b1;
      mem[8'h07] = 1'b1;
      test_reset();
      test_write();
      test_read();
      test_rmw();
      test_errors();
      test_back_to_back();
      test_abort();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
